// File: rtl/tlb_op_seq_if.sv
// Shared TLB entry type plus the op/array/cp0 bundle between the pipeline, cp0,
// the TLB entry array and the TLB op sequencer.
package tlb_op_seq_pkg;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [23:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [23:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        OpTlbr  = 2'b00,
        OpTlbwi = 2'b01,
        OpTlbwr = 2'b10,
        OpTlbp  = 2'b11
    } tlb_op_e;

endpackage

interface tlb_op_seq_if #(
    parameter int unsigned N_TLB_ENTRIES = 32
);
    import tlb_op_seq_pkg::*;

    localparam int unsigned TLB_WIDTH = $clog2(N_TLB_ENTRIES);

    logic                 op_valid;
    logic [1:0]           op_type;
    logic                 op_ready;
    logic                 flush;
    logic [TLB_WIDTH-1:0] cp0_index;
    logic [TLB_WIDTH-1:0] cp0_random;
    logic [31:0]          cp0_entry_hi;
    tlb_entry_t           tlbrw_wrdata;
    logic                 tlb_re;
    logic [TLB_WIDTH-1:0] tlb_raddr;
    tlb_entry_t           tlb_rdata;
    logic                 tlb_we;
    logic [TLB_WIDTH-1:0] tlb_waddr;
    tlb_entry_t           tlb_wdata;
    logic                 tlbr_req;
    tlb_entry_t           tlbr_res;
    logic                 tlbp_req;
    logic [31:0]          tlbp_res;
    logic                 tlbwr_req;
    logic                 busy;

    modport master (
        output op_valid, op_type, flush, cp0_index, cp0_random, cp0_entry_hi, tlbrw_wrdata,
               tlb_rdata,
        input  op_ready, tlb_re, tlb_raddr, tlb_we, tlb_waddr, tlb_wdata, tlbr_req, tlbr_res,
               tlbp_req, tlbp_res, tlbwr_req, busy
    );

    modport slave (
        input  op_valid, op_type, flush, cp0_index, cp0_random, cp0_entry_hi, tlbrw_wrdata,
               tlb_rdata,
        output op_ready, tlb_re, tlb_raddr, tlb_we, tlb_waddr, tlb_wdata, tlbr_req, tlbr_res,
               tlbp_req, tlbp_res, tlbwr_req, busy
    );

endinterface

// File: rtl/tlb_op_seq.sv
// Sequencer for TLBR/TLBWI/TLBWR/TLBP: drives the single-port synchronous TLB
// array, scans serially for TLBP and returns results to cp0 as one-cycle pulses.
module tlb_op_seq
    import tlb_op_seq_pkg::*;
#(
    parameter int unsigned N_TLB_ENTRIES = 32
) (
    input logic        clk,
    input logic        rst,
    tlb_op_seq_if.slave bus
);

    localparam int unsigned TLB_WIDTH = $clog2(N_TLB_ENTRIES);
    localparam int unsigned CNT_WIDTH = TLB_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StWrite, StReadWait, StProbe} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    tlb_op_e              op_q, op_d;
    logic [TLB_WIDTH-1:0] index_q, index_d;
    logic [TLB_WIDTH-1:0] random_q, random_d;
    logic [18:0]          vpn2_q, vpn2_d;
    logic [7:0]           asid_q, asid_d;
    tlb_entry_t           wdata_q, wdata_d;
    tlb_entry_t           tlbr_res_q, tlbr_res_d;
    logic [31:0]          tlbp_res_q, tlbp_res_d;

    logic                 op_ready, tlb_re, tlb_we, tlbr_req, tlbp_req, tlbwr_req, kill, match;
    logic [TLB_WIDTH-1:0] tlb_raddr, hit_idx;
    logic [31:0]          tlbp_val;

    logic unused_entry_hi;
    assign unused_entry_hi = ^bus.cp0_entry_hi[12:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            op_q       <= OpTlbr;
            index_q    <= '0;
            random_q   <= '0;
            vpn2_q     <= '0;
            asid_q     <= '0;
            wdata_q    <= '0;
            tlbr_res_q <= '0;
            tlbp_res_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            op_q       <= op_d;
            index_q    <= index_d;
            random_q   <= random_d;
            vpn2_q     <= vpn2_d;
            asid_q     <= asid_d;
            wdata_q    <= wdata_d;
            tlbr_res_q <= tlbr_res_d;
            tlbp_res_q <= tlbp_res_d;
        end
    end

    assign match = (bus.tlb_rdata.vpn2 == vpn2_q) &&
                   (bus.tlb_rdata.g || (bus.tlb_rdata.asid == asid_q));
    // Compare slot trails the issue counter by one cycle.
    assign hit_idx = cnt_q[TLB_WIDTH-1:0] - TLB_WIDTH'(1);
    // A flushed or reset cycle must have no architectural effect.
    assign kill = bus.flush | rst;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        op_d      = op_q;
        index_d   = index_q;
        random_d  = random_q;
        vpn2_d    = vpn2_q;
        asid_d    = asid_q;
        wdata_d   = wdata_q;
        op_ready  = 1'b0;
        tlb_re    = 1'b0;
        tlb_raddr = '0;
        tlb_we    = 1'b0;
        tlbr_req  = 1'b0;
        tlbp_req  = 1'b0;
        tlbwr_req = 1'b0;
        tlbp_val  = 32'h8000_0000;

        unique case (state_q)
            StIdle: begin
                op_ready = ~bus.flush;
                if (bus.op_valid && op_ready) begin
                    op_d     = tlb_op_e'(bus.op_type);
                    index_d  = bus.cp0_index;
                    random_d = bus.cp0_random;
                    vpn2_d   = bus.cp0_entry_hi[31:13];
                    asid_d   = bus.cp0_entry_hi[7:0];
                    wdata_d  = bus.tlbrw_wrdata;
                    cnt_d    = '0;
                    pend_d   = 1'b0;
                    case (tlb_op_e'(bus.op_type))
                        OpTlbwi, OpTlbwr: state_d = StWrite;
                        OpTlbr:           state_d = StReadWait;
                        default:          state_d = StProbe;
                    endcase
                end
            end
            StWrite: begin
                tlb_we    = ~kill;
                tlbwr_req = ~kill && (op_q == OpTlbwr);
                state_d   = StIdle;
            end
            StReadWait: begin
                if (!pend_q) begin
                    tlb_re    = ~kill;
                    tlb_raddr = index_q;
                    pend_d    = 1'b1;
                end else begin
                    tlbr_req = ~kill;
                    state_d  = StIdle;
                end
            end
            StProbe: begin
                if (!cnt_q[TLB_WIDTH]) begin
                    tlb_re    = ~kill;
                    tlb_raddr = cnt_q[TLB_WIDTH-1:0];
                    cnt_d     = cnt_q + CNT_WIDTH'(1);
                end
                pend_d = ~cnt_q[TLB_WIDTH];
                if (pend_q) begin
                    if (match) begin
                        tlbp_req = ~kill;
                        tlbp_val = 32'(hit_idx);
                        state_d  = StIdle;
                    end else if (cnt_q[TLB_WIDTH]) begin
                        tlbp_req = ~kill;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus.flush && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    assign tlbr_res_d = tlbr_req ? bus.tlb_rdata : tlbr_res_q;
    assign tlbp_res_d = tlbp_req ? tlbp_val : tlbp_res_q;

    assign bus.op_ready  = op_ready;
    assign bus.busy      = ~op_ready;
    assign bus.tlb_re    = tlb_re;
    assign bus.tlb_raddr = tlb_raddr;
    assign bus.tlb_we    = tlb_we;
    assign bus.tlb_waddr = (op_q == OpTlbwr) ? random_q : index_q;
    assign bus.tlb_wdata = wdata_q;
    assign bus.tlbr_req  = tlbr_req;
    assign bus.tlbr_res  = tlbr_res_d;
    assign bus.tlbp_req  = tlbp_req;
    assign bus.tlbp_res  = tlbp_res_d;
    assign bus.tlbwr_req = tlbwr_req;

endmodule

// File: tb/tb_tlb_op_seq.sv
// Directed bench for tlb_op_seq: vector table for write/read ops plus
// hand-written probe, flush and reset sequences against a behavioural TLB array.
module tb_tlb_op_seq;
    import tlb_op_seq_pkg::*;

    localparam int unsigned N = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    tlb_entry_t mem [N];

    tlb_op_seq_if #(.N_TLB_ENTRIES(N)) bus ();

    tlb_op_seq #(.N_TLB_ENTRIES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous single-port array: data valid the cycle after tlb_re.
    always @(posedge clk) begin
        if (bus.tlb_re) bus.tlb_rdata <= mem[bus.tlb_raddr];
    end

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  idx;
        logic [4:0]  rnd;
        logic [18:0] vpn2;
        logic        exp_we;
        logic [4:0]  exp_waddr;
        logic        exp_wrreq;
        logic        exp_re;
        logic [4:0]  exp_raddr;
        logic [23:0] exp_pfn0;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives op for one cycle; returns at the T+1 sample point with cp0 inputs scrambled.
    task automatic start_op(input logic [1:0] op, input logic [4:0] idx, input logic [4:0] rnd,
                            input logic [18:0] vpn2, input logic [7:0] asid);
        tlb_entry_t w;
        w = '0;
        w.vpn2 = vpn2;
        w.pfn0 = 24'h5A5A5A;
        bus.op_type      = op;
        bus.cp0_index    = idx;
        bus.cp0_random   = rnd;
        bus.cp0_entry_hi = {vpn2, 5'd0, asid};
        bus.tlbrw_wrdata = w;
        bus.op_valid     = 1'b1;
        tick();
        bus.op_valid     = 1'b0;
        bus.cp0_index    = ~idx;
        bus.cp0_random   = ~rnd;
        bus.cp0_entry_hi = ~bus.cp0_entry_hi;
        bus.tlbrw_wrdata = ~w;
        #1;
    endtask

    task automatic probe(input logic [18:0] vpn2, input logic [7:0] asid, output int lat,
                         output logic [31:0] res, output logic all_busy);
        start_op(2'b11, 5'd0, 5'd0, vpn2, asid);
        lat = 1;
        all_busy = bus.busy;
        while (!bus.tlbp_req && lat < 40) begin
            tick();
            lat++;
            all_busy = all_busy & bus.busy;
        end
        res = bus.tlbp_res;
    endtask

    int          lat;
    logic [31:0] res;
    logic        all_busy;
    int          pulses;

    initial begin
        for (int k = 0; k < N; k++) begin
            mem[k] = '0;
            mem[k].vpn2 = 19'(k + 256);
            mem[k].asid = 8'(k);
        end
        mem[7].pfn0  = 24'h0ABCDE;
        mem[0].pfn0  = 24'h011111;
        mem[31].pfn0 = 24'hFFFFFF;
        mem[9].vpn2  = 19'h40000;
        mem[9].asid  = 8'd3;
        mem[12].vpn2 = 19'h40000;
        mem[12].asid = 8'h55;
        mem[12].g    = 1'b1;

        //          op     idx    rnd    vpn2       we    waddr  wrreq re    raddr  pfn0
        vecs[0] = '{2'b01, 5'd5,  5'd17, 19'h00123, 1'b1, 5'd5,  1'b0, 1'b0, 5'd0,  24'h0};
        vecs[1] = '{2'b10, 5'd5,  5'd31, 19'h00456, 1'b1, 5'd31, 1'b1, 1'b0, 5'd0,  24'h0};
        vecs[2] = '{2'b00, 5'd7,  5'd2,  19'h0,     1'b0, 5'd0,  1'b0, 1'b1, 5'd7,  24'h0ABCDE};
        vecs[3] = '{2'b01, 5'd0,  5'd31, 19'h7FFFF, 1'b1, 5'd0,  1'b0, 1'b0, 5'd0,  24'h0};
        vecs[4] = '{2'b00, 5'd0,  5'd9,  19'h0,     1'b0, 5'd0,  1'b0, 1'b1, 5'd0,  24'h011111};
        vecs[5] = '{2'b00, 5'd31, 5'd1,  19'h0,     1'b0, 5'd0,  1'b0, 1'b1, 5'd31, 24'hFFFFFF};

        bus.op_valid = 1'b0;
        bus.op_type = 2'b00;
        bus.flush = 1'b0;
        bus.cp0_index = '0;
        bus.cp0_random = '0;
        bus.cp0_entry_hi = '0;
        bus.tlbrw_wrdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("reset_op_ready", bus.op_ready, 1);
        chk("reset_busy", bus.busy, 0);
        chk("reset_we", bus.tlb_we, 0);
        chk("reset_re", bus.tlb_re, 0);
        chk("reset_tlbp_res", bus.tlbp_res, 0);
        chk("reset_tlbr_res", bus.tlbr_res, 0);

        for (int i = 0; i < 6; i++) begin
            vec_t v;
            v = vecs[i];
            start_op(v.op, v.idx, v.rnd, v.vpn2, 8'd0);
            chk($sformatf("v%0d_we", i), bus.tlb_we, v.exp_we);
            chk($sformatf("v%0d_wrreq", i), bus.tlbwr_req, v.exp_wrreq);
            chk($sformatf("v%0d_re", i), bus.tlb_re, v.exp_re);
            chk($sformatf("v%0d_busy", i), bus.busy, 1);
            if (v.exp_we) begin
                chk($sformatf("v%0d_waddr", i), bus.tlb_waddr, v.exp_waddr);
                chk($sformatf("v%0d_wdata", i), bus.tlb_wdata.vpn2, v.vpn2);
            end
            if (v.exp_re) chk($sformatf("v%0d_raddr", i), bus.tlb_raddr, v.exp_raddr);
            tick();
            chk($sformatf("v%0d_wrreq_t2", i), bus.tlbwr_req, 0);
            chk($sformatf("v%0d_we_t2", i), bus.tlb_we, 0);
            if (v.exp_re) begin
                chk($sformatf("v%0d_rreq", i), bus.tlbr_req, 1);
                chk($sformatf("v%0d_pfn0", i), bus.tlbr_res.pfn0, v.exp_pfn0);
                tick();
                chk($sformatf("v%0d_rres_hold", i), bus.tlbr_res.pfn0, v.exp_pfn0);
            end
            chk($sformatf("v%0d_ready", i), bus.op_ready, 1);
            chk($sformatf("v%0d_rreq_end", i), bus.tlbr_req, 0);
        end

        probe(19'h40000, 8'd3, lat, res, all_busy);
        chk("hit9_latency", lat, 11);
        chk("hit9_res", res, 32'h0000_0009);
        tick();
        chk("hit9_pulse_once", bus.tlbp_req, 0);
        chk("hit9_res_hold", bus.tlbp_res, 32'h0000_0009);
        chk("hit9_ready", bus.op_ready, 1);

        probe(19'h40000, 8'd4, lat, res, all_busy);
        chk("hitg_latency", lat, 14);
        chk("hitg_res", res, 32'h0000_000C);
        tick();

        probe(19'h7FFFF, 8'd3, lat, res, all_busy);
        chk("miss_latency", lat, 33);
        chk("miss_res", res, 32'h8000_0000);
        chk("miss_busy", all_busy, 1);
        tick();
        chk("miss_ready", bus.op_ready, 1);

        // Flush during probe at k=4.
        start_op(2'b11, 5'd0, 5'd0, 19'h40000, 8'd3);
        repeat (4) tick();
        bus.flush = 1'b1;
        #1;
        chk("flush_k4_req", bus.tlbp_req, 0);
        tick();
        bus.flush = 1'b0;
        #1;
        chk("flush_k4_idle", bus.op_ready, 1);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.tlbp_req) pulses++;
            tick();
        end
        chk("flush_k4_no_pulse", pulses, 0);
        chk("flush_k4_res_hold", bus.tlbp_res, 32'h8000_0000);

        // Flush landing on the hit cycle.
        start_op(2'b11, 5'd0, 5'd0, 19'h40000, 8'd3);
        repeat (10) tick();
        bus.flush = 1'b1;
        #1;
        chk("flush_hit_req", bus.tlbp_req, 0);
        chk("flush_hit_res", bus.tlbp_res, 32'h8000_0000);
        tick();
        bus.flush = 1'b0;
        #1;
        chk("flush_hit_idle", bus.op_ready, 1);

        // Flush in WRITE cycle.
        start_op(2'b10, 5'd5, 5'd6, 19'h1, 8'd0);
        bus.flush = 1'b1;
        #1;
        chk("flush_wr_we", bus.tlb_we, 0);
        chk("flush_wr_wrreq", bus.tlbwr_req, 0);
        tick();
        bus.flush = 1'b0;
        #1;
        chk("flush_wr_ready", bus.op_ready, 1);

        // Flush in IDLE blocks acceptance.
        bus.flush = 1'b1;
        bus.op_type = 2'b01;
        bus.op_valid = 1'b1;
        #1;
        chk("flush_idle_ready", bus.op_ready, 0);
        tick();
        bus.flush = 1'b0;
        bus.op_valid = 1'b0;
        #1;
        chk("flush_idle_no_accept", bus.busy, 0);
        chk("flush_idle_no_we", bus.tlb_we, 0);

        // Reset during READ_WAIT on the result cycle.
        start_op(2'b00, 5'd7, 5'd0, 19'h0, 8'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_rd_req", bus.tlbr_req, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_rd_ready", bus.op_ready, 1);
        chk("rst_rd_res", bus.tlbr_res, 0);
        chk("rst_rd_re", bus.tlb_re, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlb_op_seq.md
Name: tlb_op_seq

Overview:
- Sequences the privileged TLB instructions (TLBR, TLBWI, TLBWR, TLBP) between the pipeline, the TLB entry array and cp0.
- Accepts one op at a time from the WB stage.
- Drives the single-port synchronous TLB array; for TLBP it scans entries serially.
- Returns results to cp0 on its tlbr_req/tlbr_res, tlbp_req/tlbp_res and tlbwr_req inputs.
- The pipeline stalls on busy.

Parameters:
- N_TLB_ENTRIES, 32, number of TLB entries (power of two, >=2).
- TLB_WIDTH, $clog2(N_TLB_ENTRIES), entry index width (local).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op_valid  in  1  TLB op request
- op_type  in  2  00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP
- op_ready  out  1  op accepted when op_valid&op_ready
- flush  in  1  abort in-flight op
- cp0_index  in  TLB_WIDTH  cp0 Index[TLB_WIDTH-1:0]
- cp0_random  in  TLB_WIDTH  cp0 Random[TLB_WIDTH-1:0]
- cp0_entry_hi  in  32  vpn2=[31:13], asid=[7:0]
- tlbrw_wrdata  in  tlb_entry_t  entry assembled by cp0
- tlb_re  out  1  array read enable
- tlb_raddr  out  TLB_WIDTH  array read index
- tlb_rdata  in  tlb_entry_t  read data, valid the cycle after tlb_re
- tlb_we  out  1  array write enable
- tlb_waddr  out  TLB_WIDTH  write index
- tlb_wdata  out  tlb_entry_t  write data
- tlbr_req  out  1  pulse: load tlbr_res into cp0
- tlbr_res  out  tlb_entry_t  entry read by TLBR
- tlbp_req  out  1  pulse: load tlbp_res into cp0 Index
- tlbp_res  out  32  probe result: bit31 = P (miss), [TLB_WIDTH-1:0] = hit index
- tlbwr_req  out  1  pulse: advance cp0 Random
- busy  out  1  op in flight (= ~op_ready)

Behaviour:
- Reset: state IDLE; all outputs 0, except op_ready=1. Latched operands cleared to 0.
- States: IDLE, WRITE, READ_WAIT, PROBE.
- IDLE:
  - op_ready=1.
  - On accept at cycle T, latch op_type, cp0_index, cp0_random, entry_hi vpn2/asid and tlbrw_wrdata.
  - TLBWI/TLBWR -> WRITE. TLBR -> READ_WAIT, asserting tlb_re with tlb_raddr=cp0_index in cycle T+1. TLBP -> PROBE.
- WRITE (cycle T+1):
  - tlb_we=1 with tlb_wdata = latched data.
  - tlb_waddr = latched index for TLBWI, latched random for TLBWR.
  - tlbwr_req=1 for TLBWR only.
  - Next state IDLE; op_ready again at T+2.
- TLBR:
  - tlb_re at T+1; data at T+2.
  - At T+2: tlbr_req=1, tlbr_res=tlb_rdata; then IDLE.
- TLBP:
  - Counter k issues tlb_re, tlb_raddr=k at cycle T+1+k, for k = 0..N-1.
  - Data for entry k is compared at T+2+k.
  - Match condition: rdata.vpn2 == latched vpn2 && (rdata.G || rdata.asid == latched asid).
  - First match i: tlbp_req=1, tlbp_res = {1'b0, zero-extended i} at T+2+i; then IDLE. Reads already issued past i are discarded.
  - No match after entry N-1: tlbp_res=32'h8000_0000, tlbp_req=1 at T+1+N.
  - Lowest index wins on multiple matches.
- Result timing:
  - tlbp_res/tlbr_res hold their last value between pulses.
  - Pulses (tlbr_req, tlbp_req, tlbwr_req) are exactly one cycle.
- Flush:
  - In any non-IDLE state, flush forces IDLE next cycle.
  - It suppresses tlb_we, tlbr_req, tlbp_req and tlbwr_req in the same cycle; an aborted op has no architectural effect.
  - flush in IDLE blocks acceptance (op_ready=0 while flush=1).
- Operand stability: cp0 inputs are sampled only at accept; later cp0 changes do not affect an in-flight op.
- No overlap: at most one op in flight; tlb_re and tlb_we are never both 1.
- Reset mid-operation: returns to IDLE next cycle with all outputs 0; no write or result pulse is emitted.

Test Plan:
- TLBWI: cp0_index=5, wrdata.vpn2=19'h00123 -> tlb_we=1, tlb_waddr=5 at T+1; tlbwr_req=0; op_ready=1 at T+2.
- TLBWR: cp0_random=31 -> tlb_waddr=31, tlb_we=1, tlbwr_req=1 for exactly one cycle at T+1.
- TLBR: cp0_index=7, array[7].pfn0=24'hABCDE -> tlb_re/raddr=7 at T+1; tlbr_req=1 at T+2 with tlbr_res.pfn0=24'hABCDE.
- TLBP hit:
  - entry_hi vpn2=19'h40000, asid=3; entry 9 has that vpn2, asid=3; entry 12 has that vpn2 with G=1.
  - -> tlbp_req at T+11 with tlbp_res=32'h0000_0009.
  - Then G-only match (asid=4) -> tlbp_res=32'h0000_000C.
- TLBP miss: no matching entry, N=32 -> tlbp_req at T+33 with tlbp_res=32'h8000_0000; busy for cycles T+1..T+33.
- Flush/reset:
  - flush during TLBP at k=4 -> no tlbp_req; IDLE next cycle.
  - flush in WRITE cycle -> tlb_we=0.
  - rst during READ_WAIT -> tlbr_req=0, op_ready=1 after reset.
